// File: rtl/hazard_ctrl.sv
// Hazard control: load-use hold, memory-wait freeze and branch flush
// for the IF/ID register, plus PC enable and ID/EX bubble.
module hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ID_rs_i,
    input  logic [4:0]  ID_rt_i,
    input  logic [4:0]  EX_rt_i,
    input  logic        EX_memread_i,
    input  logic        branch_i,
    input  logic        imem_ack_i,
    input  logic        dmem_req_i,
    input  logic        dmem_ack_i,
    output logic        hd_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        pc_write_o,
    output logic        bubble_o,
    output logic        err_o,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        IWAIT = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              flush_pend_q;
    logic              err_q;
    logic [31:0]       stall_cnt_q;
    logic              miss_d;
    logic              miss_i;
    logic              at_limit;

    assign miss_d   = dmem_req_i && !dmem_ack_i;
    assign miss_i   = !imem_ack_i;
    assign at_limit = (cnt_q == LIMIT);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (miss_d)      state_d = DWAIT;
                else if (miss_i) state_d = IWAIT;
            end
            DWAIT: begin
                if (dmem_ack_i)  state_d = imem_ack_i ? RUN : IWAIT;
                else if (at_limit) state_d = ERR;
            end
            IWAIT: begin
                if (imem_ack_i)  state_d = RUN;
                else if (at_limit) state_d = ERR;
            end
            ERR: state_d = ERR;
        endcase
    end

    always_comb begin
        stall_o = 1'b1;
        unique case (state_q)
            RUN:   stall_o = miss_d || miss_i;
            DWAIT: stall_o = !(dmem_ack_i && imem_ack_i);
            IWAIT: stall_o = !imem_ack_i;
            ERR:   stall_o = 1'b1;
        endcase
    end

    // A frozen pipeline masks the load-use hold and defers any flush.
    assign hd_o = !stall_o && EX_memread_i && (EX_rt_i != 5'd0) &&
                  ((EX_rt_i == ID_rs_i) || (EX_rt_i == ID_rt_i));
    assign bubble_o    = hd_o;
    assign pc_write_o  = !(stall_o || hd_o);
    assign flush_o     = !stall_o && (branch_i || flush_pend_q);
    assign err_o       = err_q;
    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            err_q        <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == DWAIT || state_q == IWAIT)
                cnt_q <= cnt_q + 1'b1;
            if (state_d == ERR)
                err_q <= 1'b1;
            if (branch_i && stall_o)
                flush_pend_q <= 1'b1;
            else if (flush_o)
                flush_pend_q <= 1'b0;
            if (stall_o || hd_o)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short timeout so the
// error and ack-at-limit paths are reachable in a few cycles.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_rs, ID_rt, EX_rt;
    logic        EX_memread, branch, imem_ack, dmem_req, dmem_ack;
    logic        hd, stall, flush, pc_write, bubble, err;
    logic [1:0]  state;
    logic [31:0] stall_cnt;

    int pass_cnt = 0;
    int total    = 0;
    int exp_cnt  = 0;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ID_rs_i      (ID_rs),
        .ID_rt_i      (ID_rt),
        .EX_rt_i      (EX_rt),
        .EX_memread_i (EX_memread),
        .branch_i     (branch),
        .imem_ack_i   (imem_ack),
        .dmem_req_i   (dmem_req),
        .dmem_ack_i   (dmem_ack),
        .hd_o         (hd),
        .stall_o      (stall),
        .flush_o      (flush),
        .pc_write_o   (pc_write),
        .bubble_o     (bubble),
        .err_o        (err),
        .state_o      (state),
        .stall_cnt_o  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        total++; if (state !== 2'd0) $display("FAIL reset_state got %0d exp 0", state); else pass_cnt++;
        total++; if (err !== 1'b0) $display("FAIL reset_err got %0b exp 0", err); else pass_cnt++;
        total++; if (stall_cnt !== 32'd0) $display("FAIL reset_cnt got %0d exp 0", stall_cnt); else pass_cnt++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %0b exp 0", stall); else pass_cnt++;
        total++; if (pc_write !== 1'b1) $display("FAIL reset_pcw got %0b exp 1", pc_write); else pass_cnt++;
        total++; if (flush !== 1'b0 || hd !== 1'b0) $display("FAIL reset_flush_hd got %0b%0b exp 00", flush, hd); else pass_cnt++;
        rst = 1'b0;
        exp_cnt = 0;
        tick;
    endtask

    task automatic test_load_use;
        EX_memread = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5; ID_rt = 5'd7;
        #1;
        total++; if (hd !== 1'b1) $display("FAIL lu_hd got %0b exp 1", hd); else pass_cnt++;
        total++; if (bubble !== 1'b1) $display("FAIL lu_bubble got %0b exp 1", bubble); else pass_cnt++;
        total++; if (pc_write !== 1'b0) $display("FAIL lu_pcw got %0b exp 0", pc_write); else pass_cnt++;
        total++; if (flush !== 1'b0) $display("FAIL lu_flush got %0b exp 0", flush); else pass_cnt++;
        tick; exp_cnt++;
        EX_rt = 5'd0; ID_rs = 5'd0;
        #1;
        total++; if (hd !== 1'b0) $display("FAIL lu_r0_hd got %0b exp 0", hd); else pass_cnt++;
        total++; if (pc_write !== 1'b1) $display("FAIL lu_r0_pcw got %0b exp 1", pc_write); else pass_cnt++;
        total++; if (stall_cnt !== 32'(exp_cnt)) $display("FAIL lu_cnt got %0d exp %0d", stall_cnt, exp_cnt); else pass_cnt++;
        tick;
        EX_rt = 5'd7;
        #1;
        total++; if (hd !== 1'b1) $display("FAIL lu_rt_hd got %0b exp 1", hd); else pass_cnt++;
        tick; exp_cnt++;
        EX_memread = 1'b0;
        #1;
        total++; if (hd !== 1'b0) $display("FAIL lu_noload_hd got %0b exp 0", hd); else pass_cnt++;
        total++; if (stall_cnt !== 32'(exp_cnt)) $display("FAIL lu_cnt2 got %0d exp %0d", stall_cnt, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_branch;
        branch = 1'b1;
        #1;
        total++; if (flush !== 1'b1) $display("FAIL br_flush got %0b exp 1", flush); else pass_cnt++;
        total++; if (pc_write !== 1'b1) $display("FAIL br_pcw got %0b exp 1", pc_write); else pass_cnt++;
        tick;
        branch = 1'b0;
        #1;
        total++; if (flush !== 1'b0) $display("FAIL br_after got %0b exp 0", flush); else pass_cnt++;
    endtask

    task automatic test_dmiss;
        dmem_req = 1'b1; dmem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (stall !== 1'b1) $display("FAIL dm_stall%0d got %0b exp 1", i, stall); else pass_cnt++;
            tick; exp_cnt++;
            total++; if (state !== 2'd1) $display("FAIL dm_state%0d got %0d exp 1", i, state); else pass_cnt++;
        end
        dmem_ack = 1'b1;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL dm_ack_stall got %0b exp 0", stall); else pass_cnt++;
        tick;
        total++; if (state !== 2'd0) $display("FAIL dm_exit got %0d exp 0", state); else pass_cnt++;
        dmem_req = 1'b0; dmem_ack = 1'b0;
        #1;
        total++; if (stall_cnt !== 32'(exp_cnt)) $display("FAIL dm_cnt got %0d exp %0d", stall_cnt, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_concurrent;
        dmem_req = 1'b1; dmem_ack = 1'b0; imem_ack = 1'b0;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL cc_stall got %0b exp 1", stall); else pass_cnt++;
        tick; exp_cnt++;
        total++; if (state !== 2'd1) $display("FAIL cc_dwait got %0d exp 1", state); else pass_cnt++;
        dmem_ack = 1'b1;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL cc_dack_stall got %0b exp 1", stall); else pass_cnt++;
        tick; exp_cnt++;
        total++; if (state !== 2'd2) $display("FAIL cc_iwait got %0d exp 2", state); else pass_cnt++;
        dmem_req = 1'b0; dmem_ack = 1'b0; imem_ack = 1'b1;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL cc_iack_stall got %0b exp 0", stall); else pass_cnt++;
        tick;
        total++; if (state !== 2'd0) $display("FAIL cc_run got %0d exp 0", state); else pass_cnt++;
    endtask

    task automatic test_pending_flush;
        imem_ack = 1'b0;
        #1;
        tick; exp_cnt++;
        total++; if (state !== 2'd2) $display("FAIL pf_iwait got %0d exp 2", state); else pass_cnt++;
        branch = 1'b1;
        #1;
        total++; if (flush !== 1'b0) $display("FAIL pf_stalled_flush got %0b exp 0", flush); else pass_cnt++;
        tick; exp_cnt++;
        branch = 1'b0; imem_ack = 1'b1;
        #1;
        total++; if (flush !== 1'b1 || stall !== 1'b0) $display("FAIL pf_replay got flush=%0b stall=%0b exp 1 0", flush, stall); else pass_cnt++;
        tick;
        #1;
        total++; if (flush !== 1'b0) $display("FAIL pf_clear got %0b exp 0", flush); else pass_cnt++;
        total++; if (stall_cnt !== 32'(exp_cnt)) $display("FAIL pf_cnt got %0d exp %0d", stall_cnt, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_timeout;
        imem_ack = 1'b0;
        #1;
        tick; exp_cnt++;
        for (int i = 0; i < 4; i++) begin
            total++; if (state !== 2'd2) $display("FAIL to_iwait%0d got %0d exp 2", i, state); else pass_cnt++;
            #1;
            tick; exp_cnt++;
        end
        total++; if (state !== 2'd3) $display("FAIL to_state got %0d exp 3", state); else pass_cnt++;
        total++; if (err !== 1'b1) $display("FAIL to_err got %0b exp 1", err); else pass_cnt++;
        imem_ack = 1'b1;
        #1;
        total++; if (stall !== 1'b1 || pc_write !== 1'b0) $display("FAIL to_late_ack got stall=%0b pcw=%0b exp 1 0", stall, pc_write); else pass_cnt++;
        tick; exp_cnt++;
        total++; if (state !== 2'd3 || err !== 1'b1) $display("FAIL to_sticky got state=%0d err=%0b exp 3 1", state, err); else pass_cnt++;
        total++; if (stall_cnt !== 32'(exp_cnt)) $display("FAIL to_cnt got %0d exp %0d", stall_cnt, exp_cnt); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (state !== 2'd0 || err !== 1'b0) $display("FAIL to_rst got state=%0d err=%0b exp 0 0", state, err); else pass_cnt++;
        total++; if (stall_cnt !== 32'd0) $display("FAIL to_rst_cnt got %0d exp 0", stall_cnt); else pass_cnt++;
        total++; if (stall !== 1'b0 || flush !== 1'b0) $display("FAIL to_rst_out got stall=%0b flush=%0b exp 0 0", stall, flush); else pass_cnt++;
        rst = 1'b0;
        exp_cnt = 0;
        tick;
    endtask

    task automatic test_ack_at_limit;
        imem_ack = 1'b0;
        #1;
        tick; exp_cnt++;
        for (int i = 0; i < 3; i++) begin
            total++; if (state !== 2'd2) $display("FAIL al_iwait%0d got %0d exp 2", i, state); else pass_cnt++;
            tick; exp_cnt++;
        end
        imem_ack = 1'b1;
        #1;
        total++; if (stall !== 1'b0 || state !== 2'd2) $display("FAIL al_ack got stall=%0b state=%0d exp 0 2", stall, state); else pass_cnt++;
        tick;
        total++; if (state !== 2'd0 || err !== 1'b0) $display("FAIL al_exit got state=%0d err=%0b exp 0 0", state, err); else pass_cnt++;
        #1;
        total++; if (stall_cnt !== 32'(exp_cnt)) $display("FAIL al_cnt got %0d exp %0d", stall_cnt, exp_cnt); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0;
        EX_memread = 1'b0; branch = 1'b0;
        imem_ack = 1'b1; dmem_req = 1'b0; dmem_ack = 1'b0;
        #2;
        test_reset;
        test_load_use;
        test_branch;
        test_dmiss;
        test_concurrent;
        test_pending_flush;
        test_timeout;
        test_ack_at_limit;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
